axi4_lite_register_bank: RTL and testbench

- AXI4-Lite slave register bank that terminates the master side of the AXI4-Lite register slice.
- Provides N_REGS 32-bit control/status registers to fabric logic.
- Decodes word-aligned addresses and applies byte strobes.
- Returns OKAY/SLVERR responses with independent write and read state machines.

---
 rtl/axi4_lite_register_bank_if.sv | 33 +++
 rtl/axi4_lite_register_bank.sv | 226 ++++++++++++++++++++++
 tb/tb_axi4_lite_register_bank.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/axi4_lite_register_bank_if.sv
// rtl/axi4_lite_register_bank_if.sv - AXI4-Lite channel bundle with master/slave views
interface axi4_lite_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0]   awaddr;
   logic                awvalid;
   logic                awready;
   logic [DATA_W-1:0]   wdata;
   logic [DATA_W/8-1:0] wstrb;
   logic                wvalid;
   logic                wready;
   logic [1:0]          bresp;
   logic                bvalid;
   logic                bready;
   logic [ADDR_W-1:0]   araddr;
   logic                arvalid;
   logic                arready;
   logic [DATA_W-1:0]   rdata;
   logic [1:0]          rresp;
   logic                rvalid;
   logic                rready;

   modport master (
      output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport slave (
      input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/axi4_lite_register_bank.sv
// rtl/axi4_lite_register_bank.sv - AXI4-Lite slave bank of 32-bit control/status registers
package axi4_lite_pkg;
   typedef struct packed {
      int unsigned addr_width;
      int unsigned data_width;
   } axi4_lite_cfg_t;
endpackage

module axi4_lite_register_bank #(
   parameter axi4_lite_pkg::axi4_lite_cfg_t C = '{default: 0},
   parameter int                N_REGS    = 8,
   parameter logic [N_REGS-1:0] RO_MASK   = '0,
   parameter logic [31:0]       RESET_VAL = '0
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   axi4_lite_if.slave            axi4_s,
   output logic [N_REGS*32-1:0]  reg_out,
   input  logic [N_REGS*32-1:0]  reg_in,
   output logic [N_REGS-1:0]     wr_pulse
);
   // A zero field in the config means "use the natural 32-bit width".
   localparam int A  = (C.addr_width == 0) ? 32 : int'(C.addr_width);
   localparam int D  = (C.data_width == 0) ? 32 : int'(C.data_width);
   localparam int IW = (N_REGS > 1) ? $clog2(N_REGS) : 1;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   if (D != 32) begin : g_bad_width
      $error("axi4_lite_register_bank supports 32-bit data only");
   end

   typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} w_state_t;
   typedef enum logic       {R_IDLE, R_RESP} r_state_t;

   w_state_t      w_state_q, w_state_d;
   r_state_t      r_state_q, r_state_d;

   logic [31:0]   regs_q   [N_REGS];
   logic [31:0]   reg_in_a [N_REGS];

   logic [A-1:0]  aw_addr_q;
   logic [31:0]   w_data_q;
   logic [3:0]    w_strb_q;
   logic [1:0]    bresp_q;
   logic [31:0]   rdata_q;
   logic [1:0]    rresp_q;
   logic [N_REGS-1:0] wr_pulse_q;

   logic          awready, wready, bvalid, arready, rvalid;
   logic          commit, aw_lat_en, w_lat_en, ar_fire;
   logic [A-1:0]  c_addr, c_word, ar_word;
   logic [31:0]   c_data;
   logic [3:0]    c_strb;
   logic [IW-1:0] c_idx, ar_idx;
   logic          c_ok, ar_in_range;
   logic [31:0]   rd_data_d;
   logic [1:0]    rd_resp_d;

   for (genvar g = 0; g < N_REGS; g++) begin : g_pack
      assign reg_out[32*g +: 32] = regs_q[g];
      assign reg_in_a[g]         = reg_in[32*g +: 32];
   end

   assign axi4_s.awready = awready;
   assign axi4_s.wready  = wready;
   assign axi4_s.bvalid  = bvalid;
   assign axi4_s.bresp   = bresp_q;
   assign axi4_s.arready = arready;
   assign axi4_s.rvalid  = rvalid;
   assign axi4_s.rdata   = rdata_q;
   assign axi4_s.rresp   = rresp_q;
   assign wr_pulse       = wr_pulse_q;

   // Write FSM: collect AW and W in either order, commit when both halves are present.
   always_comb begin
      w_state_d = w_state_q;
      awready   = 1'b0;
      wready    = 1'b0;
      bvalid    = 1'b0;
      commit    = 1'b0;
      aw_lat_en = 1'b0;
      w_lat_en  = 1'b0;
      c_addr    = aw_addr_q;
      c_data    = w_data_q;
      c_strb    = w_strb_q;
      case (w_state_q)
         W_IDLE: begin
            awready = 1'b1;
            wready  = 1'b1;
            if (axi4_s.awvalid && axi4_s.wvalid) begin
               commit    = 1'b1;
               c_addr    = axi4_s.awaddr;
               c_data    = axi4_s.wdata;
               c_strb    = axi4_s.wstrb;
               w_state_d = W_RESP;
            end else if (axi4_s.awvalid) begin
               aw_lat_en = 1'b1;
               w_state_d = W_HAVE_AW;
            end else if (axi4_s.wvalid) begin
               w_lat_en  = 1'b1;
               w_state_d = W_HAVE_W;
            end
         end
         W_HAVE_AW: begin
            wready = 1'b1;
            if (axi4_s.wvalid) begin
               commit    = 1'b1;
               c_data    = axi4_s.wdata;
               c_strb    = axi4_s.wstrb;
               w_state_d = W_RESP;
            end
         end
         W_HAVE_W: begin
            awready = 1'b1;
            if (axi4_s.awvalid) begin
               commit    = 1'b1;
               c_addr    = axi4_s.awaddr;
               w_state_d = W_RESP;
            end
         end
         W_RESP: begin
            bvalid = 1'b1;
            if (axi4_s.bready) w_state_d = W_IDLE;
         end
         default: w_state_d = W_IDLE;
      endcase
   end

   // Write decode: word index, range check and read-only check.
   always_comb begin
      c_word = c_addr >> 2;
      c_idx  = c_word[IW-1:0];
      c_ok   = (c_word < A'(N_REGS)) && !RO_MASK[c_idx];
   end

   // Write FSM state, latched halves, response and strobe pulse.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         w_state_q  <= W_IDLE;
         aw_addr_q  <= '0;
         w_data_q   <= '0;
         w_strb_q   <= '0;
         bresp_q    <= RESP_OKAY;
         wr_pulse_q <= '0;
      end else begin
         w_state_q  <= w_state_d;
         wr_pulse_q <= '0;
         if (aw_lat_en) aw_addr_q <= axi4_s.awaddr;
         if (w_lat_en) begin
            w_data_q <= axi4_s.wdata;
            w_strb_q <= axi4_s.wstrb;
         end
         if (commit) begin
            bresp_q <= c_ok ? RESP_OKAY : RESP_SLVERR;
            if (c_ok) wr_pulse_q[c_idx] <= 1'b1;
         end
      end
   end

   // Register storage with per-byte strobes; read-only slots never change.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         for (int i = 0; i < N_REGS; i++) regs_q[i] <= RESET_VAL;
      end else if (commit && c_ok) begin
         for (int i = 0; i < N_REGS; i++) begin
            if (c_idx == IW'(i) && !RO_MASK[i]) begin
               for (int k = 0; k < 4; k++) begin
                  if (c_strb[k]) regs_q[i][8*k +: 8] <= c_data[8*k +: 8];
               end
            end
         end
      end
   end

   // Read FSM: accept AR when idle, hold the response until rready.
   always_comb begin
      r_state_d = r_state_q;
      arready   = 1'b0;
      rvalid    = 1'b0;
      ar_fire   = 1'b0;
      case (r_state_q)
         R_IDLE: begin
            arready = 1'b1;
            if (axi4_s.arvalid) begin
               ar_fire   = 1'b1;
               r_state_d = R_RESP;
            end
         end
         R_RESP: begin
            rvalid = 1'b1;
            if (axi4_s.rready) r_state_d = R_IDLE;
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   // Read data select; uses pre-edge register values so a same-edge write is not visible.
   always_comb begin
      ar_word     = axi4_s.araddr >> 2;
      ar_idx      = ar_word[IW-1:0];
      ar_in_range = ar_word < A'(N_REGS);
      rd_data_d   = '0;
      rd_resp_d   = RESP_SLVERR;
      if (ar_in_range) begin
         rd_resp_d = RESP_OKAY;
         rd_data_d = RO_MASK[ar_idx] ? reg_in_a[ar_idx] : regs_q[ar_idx];
      end
   end

   // Read FSM state and registered response.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_state_q <= R_IDLE;
         rdata_q   <= '0;
         rresp_q   <= RESP_OKAY;
      end else begin
         r_state_q <= r_state_d;
         if (ar_fire) begin
            rdata_q <= rd_data_d;
            rresp_q <= rd_resp_d;
         end
      end
   end
endmodule

// File: tb/tb_axi4_lite_register_bank.sv
// tb/tb_axi4_lite_register_bank.sv - directed self-checking bench for axi4_lite_register_bank
module tb_axi4_lite_register_bank;
   import axi4_lite_pkg::*;

   localparam axi4_lite_cfg_t CFG = '{addr_width: 32, data_width: 32};

   logic         aclk    = 1'b0;
   logic         aresetn = 1'b0;
   logic [255:0] reg_out;
   logic [255:0] reg_in;
   logic [7:0]   wr_pulse;
   logic [255:0] exp_regs;
   int           n_cmp = 0;
   int           n_err = 0;

   axi4_lite_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   axi4_lite_register_bank #(
      .C         (CFG),
      .N_REGS    (8),
      .RO_MASK   (8'h01),
      .RESET_VAL (32'h0)
   ) dut (
      .aclk     (aclk),
      .aresetn  (aresetn),
      .axi4_s   (bus),
      .reg_out  (reg_out),
      .reg_in   (reg_in),
      .wr_pulse (wr_pulse)
   );

   always #5 aclk = ~aclk;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge aclk);
      #1;
   endtask

   task automatic aw_w(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      bus.awaddr  = a;
      bus.awvalid = 1'b1;
      bus.wdata   = d;
      bus.wstrb   = s;
      bus.wvalid  = 1'b1;
      step();
      bus.awvalid = 1'b0;
      bus.wvalid  = 1'b0;
   endtask

   task automatic b_ack();
      bus.bready = 1'b1;
      step();
      bus.bready = 1'b0;
   endtask

   task automatic ar(input logic [31:0] a);
      bus.araddr  = a;
      bus.arvalid = 1'b1;
      step();
      bus.arvalid = 1'b0;
   endtask

   task automatic r_ack();
      bus.rready = 1'b1;
      step();
      bus.rready = 1'b0;
   endtask

   initial begin
      bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
      bus.bready = 1'b0; bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
      reg_in   = '0;
      reg_in[31:0] = 32'hCAFE_0001;
      exp_regs = '0;

      // reset state
      step(); step();
      aresetn = 1'b1;
      step();
      chk("rst_awready", 256'(bus.awready), 256'd1);
      chk("rst_wready",  256'(bus.wready),  256'd1);
      chk("rst_arready", 256'(bus.arready), 256'd1);
      chk("rst_bvalid",  256'(bus.bvalid),  256'd0);
      chk("rst_rvalid",  256'(bus.rvalid),  256'd0);
      chk("rst_reg_out", reg_out, exp_regs);
      chk("rst_pulse",   256'(wr_pulse), 256'd0);

      // AW and W together, full strobe
      aw_w(32'h04, 32'hDEAD_BEEF, 4'hF);
      exp_regs[63:32] = 32'hDEAD_BEEF;
      chk("w1_bvalid", 256'(bus.bvalid), 256'd1);
      chk("w1_bresp",  256'(bus.bresp),  256'd0);
      chk("w1_pulse",  256'(wr_pulse),   256'h02);
      b_ack();
      chk("w1_pulse_gone", 256'(wr_pulse), 256'd0);
      chk("w1_bvalid_gone", 256'(bus.bvalid), 256'd0);
      ar(32'h04);
      chk("r1_rvalid", 256'(bus.rvalid), 256'd1);
      chk("r1_rdata",  256'(bus.rdata),  256'hDEAD_BEEF);
      chk("r1_rresp",  256'(bus.rresp),  256'd0);
      r_ack();
      chk("r1_rvalid_gone", 256'(bus.rvalid), 256'd0);

      // W first, AW three cycles later, partial strobe, delayed bready
      bus.wdata  = 32'h1122_3344;
      bus.wstrb  = 4'b0101;
      bus.wvalid = 1'b1;
      step();
      bus.wvalid = 1'b0;
      chk("w2_wready_held", 256'(bus.wready),  256'd0);
      chk("w2_awready",     256'(bus.awready), 256'd1);
      chk("w2_no_bvalid",   256'(bus.bvalid),  256'd0);
      step(); step();
      bus.awaddr  = 32'h08;
      bus.awvalid = 1'b1;
      step();
      bus.awvalid = 1'b0;
      exp_regs[95:64] = 32'h0022_0044;
      chk("w2_bvalid", 256'(bus.bvalid), 256'd1);
      chk("w2_bresp",  256'(bus.bresp),  256'd0);
      chk("w2_pulse",  256'(wr_pulse),   256'h04);
      chk("w2_reg2",   256'(reg_out[95:64]), 256'h0022_0044);
      for (int i = 0; i < 5; i++) begin
         step();
         chk("w2_hold_bvalid",  256'(bus.bvalid),  256'd1);
         chk("w2_hold_bresp",   256'(bus.bresp),   256'd0);
         chk("w2_hold_awready", 256'(bus.awready), 256'd0);
         chk("w2_hold_wready",  256'(bus.wready),  256'd0);
      end
      b_ack();

      // read-only register 0
      aw_w(32'h00, 32'hFFFF_FFFF, 4'hF);
      chk("ro_bresp", 256'(bus.bresp), 256'd2);
      chk("ro_pulse", 256'(wr_pulse),  256'd0);
      b_ack();
      chk("ro_regs", reg_out, exp_regs);
      ar(32'h00);
      chk("ro_rdata", 256'(bus.rdata), 256'hCAFE_0001);
      chk("ro_rresp", 256'(bus.rresp), 256'd0);
      r_ack();

      // out of range address
      ar(32'h40);
      chk("oor_rdata", 256'(bus.rdata), 256'd0);
      chk("oor_rresp", 256'(bus.rresp), 256'd2);
      r_ack();
      aw_w(32'h40, 32'h5A5A_5A5A, 4'hF);
      chk("oor_bresp", 256'(bus.bresp), 256'd2);
      chk("oor_pulse", 256'(wr_pulse),  256'd0);
      b_ack();
      chk("oor_regs", reg_out, exp_regs);

      // read and write commit to reg3 on the same edge
      bus.araddr  = 32'h0C;
      bus.arvalid = 1'b1;
      aw_w(32'h0C, 32'h0000_0005, 4'hF);
      bus.arvalid = 1'b0;
      chk("same_rvalid", 256'(bus.rvalid), 256'd1);
      chk("same_rdata",  256'(bus.rdata),  256'd0);
      chk("same_bvalid", 256'(bus.bvalid), 256'd1);
      chk("same_reg3",   256'(reg_out[127:96]), 256'd5);
      chk("same_pulse",  256'(wr_pulse), 256'h08);
      b_ack();
      chk("same_rvalid_held", 256'(bus.rvalid), 256'd1);
      chk("same_rdata_held",  256'(bus.rdata),  256'd0);

      // asynchronous reset while a read response is pending
      aresetn = 1'b0;
      #1;
      chk("arst_rvalid", 256'(bus.rvalid), 256'd0);
      chk("arst_reg3",   256'(reg_out[127:96]), 256'd0);
      chk("arst_rdata",  256'(bus.rdata), 256'd0);
      step();
      aresetn = 1'b1;
      step();
      chk("arst_arready", 256'(bus.arready), 256'd1);
      chk("arst_awready", 256'(bus.awready), 256'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
